seg7_scan_capture: RTL and testbench

//  Receive end of the 4-digit multiplexed 7-seg bus: samples active-low anode/cathode lines
//  and reconstructs the four displayed BCD digits (th, hun, ten, one). Used as on-board

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg7_scan_capture.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan capture block.
//   SEG_0..SEG_9 : active-high segment patterns, bit6..0 = a,b,c,d,e,f,g
//   AN_*         : active-low anode selects, one per digit position
//   BCD_BAD      : digit code published for an undecodable pattern
//   state_t      : frame assembly FSM states
package seg7_pkg;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [3:0] AN_TH   = 4'b0111;
    localparam logic [3:0] AN_HUN  = 4'b1011;
    localparam logic [3:0] AN_TEN  = 4'b1101;
    localparam logic [3:0] AN_ONE  = 4'b1110;
    localparam logic [3:0] BCD_BAD = 4'hF;
    typedef enum logic [1:0] {WAIT_TH, GOT_TH, GOT_HUN, GOT_TEN} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment pattern to BCD decoder.
//   seg   in  7  active-high segments, bit6..0 = a,b,c,d,e,f,g
//   valid out 1  pattern is one of the digits 0-9
//   bcd   out 4  decoded digit, BCD_BAD when not valid
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);
    always_comb begin
        valid = 1'b1;
        bcd   = BCD_BAD;
        case (seg)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 4-digit 7-seg bus and publishes complete frames.
//   clk, rst             clock, asynchronous active-high reset
//   an_in[3:0]           active-low anodes, [3]=th .. [0]=one
//   cathodes_in[7:0]     active-low segments, bit7=dp, bit6..0=a..g
//   th,hun,ten,one[3:0]  digits of the last complete frame (4'hF = undecodable)
//   frame_done           1-cycle pulse when a frame is published
//   seg_err              1-cycle pulse after capturing a non-digit pattern
//   stale                no capture for TIMEOUT_CYCLES; cleared by the next frame
//   dp_out[3:0]          per-digit decimal points, only when SEG7_CAP_DP_EN is defined
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an_in,
    input  logic [7:0] cathodes_in,
    output logic [3:0] th,
    output logic [3:0] hun,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic       frame_done,
    output logic       seg_err,
    output logic       stale
`ifdef SEG7_CAP_DP_EN
    ,
    output logic [3:0] dp_out
`endif
);
`ifdef SEG7_CAP_DP_EN
    localparam int PW = 12;
    logic [PW-1:0] bus;
    assign bus = {an_in, cathodes_in};
`else
    // dp is dropped before the synchronizer so it cannot disturb the settle count
    localparam int PW = 11;
    logic [PW-1:0] bus;
    logic          unused_dp;
    assign bus       = {an_in, cathodes_in[6:0]};
    assign unused_dp = cathodes_in[7];
`endif
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    logic [PW-1:0]    sync_q [SYNC_STAGES];
    logic [PW-1:0]    pair;
    logic [3:0]       an;
    logic [SET_W-1:0] settle;
    logic [TO_W-1:0]  idle;
    logic             dwell, changed, one_low, capture, timeout, publish, valid;
    logic [3:0]       bcd, sh_th, sh_hun, sh_ten;
    state_t           state, state_n;

    assign pair    = sync_q[SYNC_STAGES-1];
    assign an      = pair[PW-1 -: 4];
    // comparing against the stage before the last means the counter restarts on the
    // same edge the synced pair changes, giving SYNC_STAGES+SETTLE_CYCLES latency
    assign changed = sync_q[SYNC_STAGES-2] != pair;
    assign one_low = an inside {AN_TH, AN_HUN, AN_TEN, AN_ONE};
    assign capture = settle == SET_LAST && one_low && !dwell;
    assign timeout = !capture && idle == TO_LAST;

    seg7_to_bcd u_dec (
        .seg   (~pair[6:0]),
        .valid (valid),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            settle <= '0;
            idle   <= '0;
            dwell  <= 1'b0;
        end else begin
            sync_q[0] <= bus;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            settle <= changed ? '0 : (settle == SET_LAST ? settle : settle + 1'b1);
            idle   <= capture ? '0 : (idle == TO_MAX ? idle : idle + 1'b1);
            dwell  <= changed ? 1'b0 : (dwell | capture);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_TH;
        else     state <= state_n;
    end

    // any th capture restarts a frame; any other out-of-order capture abandons it
    always_comb begin
        state_n = state;
        publish = 1'b0;
        if (capture) begin
            if (an == AN_TH)                         state_n = GOT_TH;
            else if (an == AN_HUN && state == GOT_TH)  state_n = GOT_HUN;
            else if (an == AN_TEN && state == GOT_HUN) state_n = GOT_TEN;
            else begin
                state_n = WAIT_TH;
                publish = an == AN_ONE && state == GOT_TEN;
            end
        end else if (timeout) begin
            state_n = WAIT_TH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_th      <= '0;
            sh_hun     <= '0;
            sh_ten     <= '0;
            th         <= '0;
            hun        <= '0;
            ten        <= '0;
            one        <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            stale      <= 1'b0;
        end else begin
            frame_done <= publish;
            seg_err    <= capture && !valid;
            if (capture && an == AN_TH)  sh_th  <= bcd;
            if (capture && an == AN_HUN) sh_hun <= bcd;
            if (capture && an == AN_TEN) sh_ten <= bcd;
            if (publish) begin
                th    <= sh_th;
                hun   <= sh_hun;
                ten   <= sh_ten;
                one   <= bcd;
                stale <= 1'b0;
            end else if (timeout) begin
                stale <= 1'b1;
            end
        end
    end

`ifdef SEG7_CAP_DP_EN
    logic [3:1] sh_dp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_dp  <= '0;
            dp_out <= '0;
        end else begin
            if (capture && an == AN_TH)  sh_dp[3] <= ~pair[7];
            if (capture && an == AN_HUN) sh_dp[2] <= ~pair[7];
            if (capture && an == AN_TEN) sh_dp[1] <= ~pair[7];
            if (publish) dp_out <= {sh_dp, ~pair[7]};
        end
    end
`endif
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed and random stimulus against a frame-level reference model.
module tb_seg7_scan_capture;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int TMO    = 300;
    localparam int HL     = SYNC + SETTLE + 1;
    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an_in = 4'hF;
    logic [7:0] cathodes_in = 8'hFF;
    logic [3:0] th, hun, ten, one;
    logic       frame_done, seg_err, stale;
`ifdef SEG7_CAP_DP_EN
    logic [3:0] dp_out;
`endif

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .SYNC_STAGES    (SYNC),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .cathodes_in (cathodes_in),
        .th          (th),
        .hun         (hun),
        .ten         (ten),
        .one         (one),
        .frame_done  (frame_done),
        .seg_err     (seg_err),
`ifdef SEG7_CAP_DP_EN
        .dp_out      (dp_out),
`endif
        .stale       (stale)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cb(input int d, input logic dp);
        return {~dp, ~PAT[d]};
    endfunction

    function automatic int position(input logic [3:0] a);
        if ($countones(~a) != 1) return -1;
        for (int k = 0; k < 4; k++) if (!a[k]) return k;
        return -1;
    endfunction

    function automatic logic [11:0] sample();
`ifdef SEG7_CAP_DP_EN
        return {an_in, cathodes_in};
`else
        return {an_in, 1'b1, cathodes_in[6:0]};
`endif
    endfunction

    // reference: a capture is the first edge a one-hot-low pair has been stable for
    // SETTLE samples (seen SYNC samples late); a frame is the last four captures being
    // th,hun,ten,one in order since the last reset/timeout/publish
    logic [11:0] hist [HL];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dp;
    logic        m_fd, m_se, m_stale;
    int          m_idle;
    int          q_pos [$];
    logic [3:0]  q_val [$];
    logic        q_dp  [$];

    always @(posedge clk or posedge rst) begin
        bit cap;
        int p;
        logic [3:0] v;
        if (rst) begin
            for (int i = 0; i < HL; i++) hist[i] = '1;
            for (int k = 0; k < 4; k++) m_dig[k] = '0;
            m_dp = '0; m_fd = 0; m_se = 0; m_stale = 0; m_idle = 0;
            q_pos.delete(); q_val.delete(); q_dp.delete();
        end else begin
            for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sample();
            cap = hist[SYNC+SETTLE] != hist[SYNC];
            for (int i = SYNC + 1; i < SYNC + SETTLE; i++) if (hist[i] != hist[SYNC]) cap = 0;
            p = position(hist[SYNC][11:8]);
            if (p < 0) cap = 0;
            m_fd = 0;
            m_se = 0;
            if (cap) begin
                v = 4'hF;
                for (int k = 0; k < 10; k++) if (~hist[SYNC][6:0] == PAT[k]) v = 4'(k);
                m_se = v == 4'hF;
                q_pos.push_back(p); q_val.push_back(v); q_dp.push_back(~hist[SYNC][7]);
                if (q_pos.size() > 4) begin
                    void'(q_pos.pop_front()); void'(q_val.pop_front()); void'(q_dp.pop_front());
                end
                if (q_pos.size() == 4 && q_pos[0] == 3 && q_pos[1] == 2 && q_pos[2] == 1 && q_pos[3] == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        m_dig[k] = q_val[k];
                        m_dp[3-k] = q_dp[k];
                    end
                    m_fd = 1;
                    m_stale = 0;
                    q_pos.delete(); q_val.delete(); q_dp.delete();
                end
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_stale = 1;
                    q_pos.delete(); q_val.delete(); q_dp.delete();
                end
            end
        end
    end

    int   cyc = 0, fd_cnt = 0, se_cnt = 0, c_fd = 0, c_st = 0;
    logic st_q = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        check("outputs", {13'd0, th, hun, ten, one, frame_done, seg_err, stale},
              {13'd0, m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_fd, m_se, m_stale});
`ifdef SEG7_CAP_DP_EN
        check("dp_out", {28'd0, dp_out}, {28'd0, m_dp});
`endif
        if (frame_done) begin
            fd_cnt++;
            c_fd = cyc;
        end
        if (seg_err) se_cnt++;
        if (stale && !st_q) c_st = cyc;
        st_q = stale;
    end

    task automatic show(input logic [3:0] a, input logic [7:0] c, input int n);
        an_in = a;
        cathodes_in = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0);
        show(4'b0111, cb(d3, 0), 8);
        show(4'b1011, cb(d2, 0), 8);
        show(4'b1101, cb(d1, 0), 8);
        show(4'b1110, cb(d0, 0), 8);
        show(4'b1111, 8'hFF, 4);
    endtask

    initial begin
        int f0, s0, r, n;
        logic [3:0] a;
        logic [7:0] c;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {th, hun, ten, one, frame_done, seg_err, stale}, 19'd0);

        // 1: basic frame
        f0 = fd_cnt; s0 = se_cnt;
        show(4'b0111, 8'hCF, 8); show(4'b1011, 8'h92, 8);
        show(4'b1101, 8'h86, 8); show(4'b1110, 8'hCC, 8);
        show(4'b1111, 8'hFF, 4);
        check("t1_frames", fd_cnt - f0, 1);
        check("t1_digits", {th, hun, ten, one}, 16'h1234);
        check("t1_seg_err", se_cnt - s0, 0);

        // 2: short glitch on the hun slot before it settles
        f0 = fd_cnt;
        show(4'b0111, cb(5, 0), 8);
        show(4'b1011, 8'h92, 2); show(4'b1011, 8'h86, 2); show(4'b1011, 8'h92, 10);
        show(4'b1101, cb(7, 0), 8); show(4'b1110, cb(8, 0), 8);
        show(4'b1111, 8'hFF, 4);
        check("t2_frames", fd_cnt - f0, 1);
        check("t2_digits", {th, hun, ten, one}, 16'h5278);

        // 3: out-of-order scan, then a proper frame
        f0 = fd_cnt;
        show(4'b0111, cb(9, 0), 8); show(4'b1101, cb(1, 0), 8);
        show(4'b1011, cb(2, 0), 8); show(4'b1110, cb(3, 0), 8);
        show(4'b1111, 8'hFF, 4);
        check("t3_no_frame", fd_cnt - f0, 0);
        check("t3_unchanged", {th, hun, ten, one}, 16'h5278);
        frame(9, 0, 1, 2);
        check("t3_frames", fd_cnt - f0, 1);
        check("t3_digits", {th, hun, ten, one}, 16'h9012);

        // 4: undecodable ten
        f0 = fd_cnt; s0 = se_cnt;
        show(4'b0111, cb(4, 0), 8); show(4'b1011, cb(3, 0), 8);
        show(4'b1101, 8'hFE, 8); show(4'b1110, cb(7, 0), 8);
        show(4'b1111, 8'hFF, 4);
        check("t4_seg_err", se_cnt - s0, 1);
        check("t4_frames", fd_cnt - f0, 1);
        check("t4_digits", {th, hun, ten, one}, 16'h43F7);

        // 5: timeout on a blank bus
        show(4'b1111, 8'hFF, TMO + 20);
        check("t5_stale", stale, 1);
        check("t5_stale_delay", c_st - c_fd, TMO);
        f0 = fd_cnt;
        frame(1, 2, 3, 4);
        check("t5_stale_clear", stale, 0);
        check("t5_frames", fd_cnt - f0, 1);

        // 6: reset mid-frame
        show(4'b0111, cb(6, 0), 8); show(4'b1011, cb(5, 0), 8);
        show(4'b1101, cb(4, 0), 3);
        rst = 1'b1;
        #1;
        check("t6_reset_now", {th, hun, ten, one, frame_done, seg_err, stale}, 19'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        f0 = fd_cnt;
        show(4'b1101, cb(4, 0), 8); show(4'b1110, cb(3, 0), 8);
        show(4'b1111, 8'hFF, 4);
        check("t6_no_frame", fd_cnt - f0, 0);
        check("t6_digits", {th, hun, ten, one}, 16'h0000);

        // random scan traffic with glitches, bad patterns, blanks and resets
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      a = ~(4'(1) << (3 - i % 4));
            else if (r < 88) a = 4'hF;
            else             a = 4'($urandom);
            c = (r % 10 == 3) ? 8'($urandom) : cb(int'($urandom_range(0, 9)), 1'($urandom));
            n = (r % 7 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 10));
            if (r == 99) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            show(a, c, n);
        end
        show(4'b1111, 8'hFF, 10);
        check("rand_activity", (fd_cnt > 20) ? 1 : 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
